snake_input_controller: RTL and testbench
=========================================

# snake_input_controller

Converts the board's four active-low direction push-buttons and a pause button into a debounced, reversal-safe snake heading and a periodic game-step strobe. Sits directly upstream of `game_controller`, which advances the snake one cell per `tick` using `dir`, and rewrites `grid_flat` for `vga_interface`. All logic is in the 50 MHz `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz). Stable-level count required to accept a button change. Must be ≥2.
- `TICK_CYCLES`, default 5_000_000 (10 Hz). Game-step period in `clk` cycles. Must be ≥2.
- `clk`  input  1  50 MHz system clock.
- `rst_n`  input  1  Reset, asynchronous and active-low.
- `key_n`  input  4  Raw direction buttons, active-low, asynchronous: [0]=up, [1]=right, [2]=down, [3]=left.
- `pause_key_n`  input  1  Raw pause button, active-low, asynchronous.
- `dir`  output  2  Committed heading: 00 up, 01 right, 10 down, 11 left.
- `tick`  output  1  One-cycle game-step strobe.
- `paused`  output  1  High while the game is paused.

## Operation
- **Synchronizer:** two flops per button (5 total), reset to 1 (released).
- **Debounce:** each button has a `stable` level (reset 1) and a counter sized `$clog2(DEBOUNCE_CYCLES)`.
  - Synced level equals `stable`: counter clears.
  - Synced level differs from `stable`: counter increments. When it reaches DEBOUNCE_CYCLES-1 while the level still differs, `stable` takes the new level and the counter clears.
  - A `stable` transition 1→0 produces a one-cycle press event. Releases produce no event.
- **Pending heading:** register `pending`, reset 01.
  - On a direction press event with `paused`=0, requested direction d is written to `pending` unless d is the opposite of the reference heading (opposite = d XOR 2'b10). A rejected press leaves `pending` unchanged.
  - The reference heading is `dir`, except in a commit cycle, where it is the value being committed (current `pending`).
  - More presses in the same tick interval overwrite `pending`: the last accepted press wins.
  - Several direction press events in one cycle: the highest priority is used (up > right > down > left) and the rest are discarded.
- **Step timer:** counter sized `$clog2(TICK_CYCLES)`, reset 0, counts 0..TICK_CYCLES-1 and wraps.
  - At terminal count with `paused`=0 (the commit cycle), `dir` <= `pending` and `tick` <= 1 on the same edge. `tick` is 1 for exactly one cycle.
  - While `paused`=1, the counter holds, `tick` stays 0 and direction press events are dropped.
- **Pause:** a pause press event toggles `paused`.
  - Leaving pause also clears the step counter, so the first tick after resume comes a full TICK_CYCLES later.
  - Entering pause on the same cycle as terminal count suppresses that tick.
- **Reset:** asserting `rst_n`=0 at any time immediately forces every output and every register to its reset value:
  - `dir`=01, `tick`=0, `paused`=0.
  - `pending`=01, counters 0, `stable`=1, synchronizers 1.
  - An in-progress debounce or tick interval is discarded.

## Timing
- Button held low steadily from the first edge that samples it low: the press event fires on edge DEBOUNCE_CYCLES+2 and `pending` updates on that same edge. The effect is visible at the next commit.
- A low glitch shorter than DEBOUNCE_CYCLES synced cycles produces no event. The same holds for bounce, because the counter clears on any match.
- `tick` and a new `dir` become visible on the same cycle. `dir` stays constant between ticks, so `game_controller` samples `dir` when `tick`=1.
- Tick period is exactly TICK_CYCLES cycles while unpaused. First tick after reset release is at cycle TICK_CYCLES.
- Release of `rst_n` is expected synchronous to `clk` from the top-level reset bridge. The block contains no reset synchronizer.

## Test plan
Sim parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
1. Reset then idle for 35 cycles -> `tick` pulses at cycles 10, 20, 30, each 1 cycle wide; `dir`=01 throughout; `paused`=0.
2. Hold `key_n[2]` (down) low for 8 cycles starting at cycle 1 -> `pending`=10 by cycle 7; at cycle 10 `tick`=1 with `dir`=10. A 3-cycle low pulse instead -> `dir` stays 01.
3. With `dir`=01, press left (11) -> rejected, `dir` stays 01. Then press up, then left, in the same interval -> up accepted, left rejected because the reference is still 01; next tick gives `dir`=00.
4. Press up and down in the same cycle -> up wins, `dir`=00 at the next tick. A press event landing on the commit cycle is checked against the committed value and applies at the following tick.
5. Pause press at cycle 5 -> `paused`=1, no ticks and direction presses ignored. Second pause press -> `paused`=0 and the next tick arrives exactly 10 cycles later.
6. Drive `rst_n` low mid-interval with `dir`=10 and `paused`=1 -> outputs immediately return to `dir`=01, `tick`=0, `paused`=0; after release the first tick comes at cycle 10.

Source files
------------

// File: rtl/snake_input_controller.sv
// Direction/pause button front end for the snake game: synchronizes and debounces
// the raw buttons, filters 180-degree reversals and emits the periodic game-step strobe.
module snake_input_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic       pause_key_n,
    output logic [1:0] dir,
    output logic       tick,
    output logic       paused
);

    localparam int NUM_BTN   = 5;
    localparam int PAUSE_IDX = 4;
    localparam int DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam int TK_W      = $clog2(TICK_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    // Button synchronizers, index 4 is the pause button.
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Debounce state.
    logic [NUM_BTN-1:0]           stable_q;
    logic [NUM_BTN-1:0]           stable_d;
    logic [NUM_BTN-1:0][DB_W-1:0] db_cnt_q;
    logic [NUM_BTN-1:0][DB_W-1:0] db_cnt_d;
    logic [NUM_BTN-1:0]           press;

    // Heading selection and step control.
    logic       dir_ev;
    logic [1:0] req_dir;
    logic       pause_ev;
    logic       terminal;
    logic       commit;
    logic [1:0] ref_dir;

    state_t          state_q;
    state_t          state_d;
    logic [TK_W-1:0] tick_cnt_q;
    logic [TK_W-1:0] tick_cnt_d;
    logic [1:0]      pending_q;
    logic [1:0]      pending_d;
    logic [1:0]      dir_q;
    logic [1:0]      dir_d;
    logic            tick_q;
    logic            tick_d;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours (the two-flop chain depends on it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {pause_key_n, key_n};
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        press    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
                press[i]    = stable_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '1;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Simultaneous direction presses resolve as up > right > down > left.
    always_comb begin
        req_dir = DIR_UP;
        if (press[0]) begin
            req_dir = DIR_UP;
        end else if (press[1]) begin
            req_dir = DIR_RIGHT;
        end else if (press[2]) begin
            req_dir = DIR_DOWN;
        end else if (press[3]) begin
            req_dir = DIR_LEFT;
        end
    end

    assign dir_ev   = |press[3:0];
    assign pause_ev = press[PAUSE_IDX];
    assign terminal = (tick_cnt_q == TK_LAST);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        pending_d  = pending_q;
        dir_d      = dir_q;
        commit     = 1'b0;
        ref_dir    = dir_q;

        case (state_q)
            ST_RUN: begin
                // Entering pause freezes the timer and swallows a coincident tick.
                if (pause_ev) begin
                    state_d = ST_PAUSED;
                end else begin
                    commit     = terminal;
                    tick_cnt_d = terminal ? '0 : tick_cnt_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (pause_ev) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // On a commit edge the heading being committed is the reversal reference.
        if (commit) begin
            dir_d   = pending_q;
            ref_dir = pending_q;
        end

        if ((state_q == ST_RUN) && dir_ev && (req_dir != (ref_dir ^ 2'b10))) begin
            pending_d = req_dir;
        end
    end

    assign tick_d = commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            tick_cnt_q <= '0;
            pending_q  <= DIR_RIGHT;
            dir_q      <= DIR_RIGHT;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
        end
    end

    assign dir    = dir_q;
    assign tick   = tick_q;
    assign paused = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_snake_input_controller.sv
// Scoreboard bench for snake_input_controller: scenarios push the expected (cycle, dir)
// of every tick, and an independent monitor pops and compares each tick the DUT emits.
module tb_snake_input_controller;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int TICK_CYCLES     = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       pause_key_n = 1'b1;
    logic [1:0] dir;
    logic       tick;
    logic       paused;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;

    snake_input_controller #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TICK_CYCLES    (TICK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .pause_key_n(pause_key_n),
        .dir        (dir),
        .tick       (tick),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    // Cycle N is the interval following the N-th rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_tick(input int c, input logic [1:0] d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        sb_q.push_back(e);
    endtask

    task automatic at(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_cycle: reached %0d, expected %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        key_n       = 4'hF;
        pause_key_n = 1'b1;
        #1;
        check("rst_dir", dir, 2'b01);
        check("rst_tick", tick, 0);
        check("rst_paused", paused, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every tick the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tick) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_tick: tick at cycle %0d dir=%b, none expected", cyc, dir);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_dir", dir, e.dir);
                check("tick_paused", paused, 0);
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Idle: ticks at 10/20/30, heading stays right.
        do_reset();
        expect_tick(10, 2'b01);
        expect_tick(20, 2'b01);
        expect_tick(30, 2'b01);
        at(35);
        check("idle_dir", dir, 2'b01);
        check("idle_paused", paused, 0);
        check("idle_sb_empty", sb_q.size(), 0);

        // Down held 8 cycles: event on edge 6, committed at tick 10.
        do_reset();
        expect_tick(10, 2'b10);
        expect_tick(20, 2'b10);
        at(0); key_n[2] = 1'b0;
        at(8); key_n[2] = 1'b1;
        at(22);
        check("down_dir", dir, 2'b10);
        check("down_sb_empty", sb_q.size(), 0);

        // Three-cycle glitch: filtered out.
        do_reset();
        expect_tick(10, 2'b01);
        at(0); key_n[2] = 1'b0;
        at(3); key_n[2] = 1'b1;
        at(12);
        check("glitch_dir", dir, 2'b01);
        check("glitch_sb_empty", sb_q.size(), 0);

        // Left rejected; then up (edge 16) accepted, left (edge 18) rejected against dir=01.
        do_reset();
        expect_tick(10, 2'b01);
        expect_tick(20, 2'b00);
        at(0);  key_n[3] = 1'b0;
        at(6);  key_n[3] = 1'b1;
        at(10); key_n[0] = 1'b0;
        at(12); key_n[3] = 1'b0;
        at(14); key_n[0] = 1'b1;
        at(16); key_n[3] = 1'b1;
        at(22);
        check("rev_dir", dir, 2'b00);
        check("rev_sb_empty", sb_q.size(), 0);

        // Up+down together: up wins. Then presses landing on commit edges 20 and 30.
        do_reset();
        expect_tick(10, 2'b00);
        expect_tick(20, 2'b11);
        expect_tick(30, 2'b11);
        expect_tick(40, 2'b10);
        at(0);  key_n[0] = 1'b0; key_n[2] = 1'b0;
        at(5);  key_n[0] = 1'b1; key_n[2] = 1'b1;
        at(10); key_n[3] = 1'b0;
        at(14); key_n[3] = 1'b1; key_n[1] = 1'b0;
        at(18); key_n[1] = 1'b1;
        at(24); key_n[2] = 1'b0;
        at(28); key_n[2] = 1'b1;
        at(42);
        check("prio_dir", dir, 2'b10);
        check("prio_sb_empty", sb_q.size(), 0);

        // Pause at edge 6, down dropped while paused, resume at edge 26 -> tick at 36.
        do_reset();
        expect_tick(36, 2'b01);
        at(0);  pause_key_n = 1'b0;
        at(4);  pause_key_n = 1'b1;
        at(8);
        check("pause_on", paused, 1);
        at(10); key_n[2] = 1'b0;
        at(14); key_n[2] = 1'b1;
        at(20); pause_key_n = 1'b0;
        at(24); pause_key_n = 1'b1;
        at(25);
        check("pause_still", paused, 1);
        at(27);
        check("pause_off", paused, 0);
        at(38);
        check("pause_dir", dir, 2'b01);
        check("pause_sb_empty", sb_q.size(), 0);

        // Pause on the terminal-count edge suppresses that tick; resume at 20 -> tick at 30.
        do_reset();
        expect_tick(30, 2'b01);
        at(4);  pause_key_n = 1'b0;
        at(8);  pause_key_n = 1'b1;
        at(12);
        check("tcpause_on", paused, 1);
        at(14); pause_key_n = 1'b0;
        at(18); pause_key_n = 1'b1;
        at(32);
        check("tcpause_off", paused, 0);
        check("tcpause_sb_empty", sb_q.size(), 0);

        // Reset mid-interval with dir=10 and paused=1.
        do_reset();
        expect_tick(10, 2'b10);
        at(0);  key_n[2] = 1'b0;
        at(8);  key_n[2] = 1'b1;
        at(10); pause_key_n = 1'b0;
        at(14); pause_key_n = 1'b1;
        at(18);
        check("prerst_dir", dir, 2'b10);
        check("prerst_paused", paused, 1);
        do_reset();
        expect_tick(10, 2'b01);
        at(12);
        check("postrst_dir", dir, 2'b01);
        check("postrst_paused", paused, 0);
        check("postrst_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
